tensor_serializer: RTL and testbench

Streams a packed tensor bus out one element at a time over a valid/ready handshake. It sits on the output of the residual-block datapath: it reads the flat `x_out` word produced by `resblock` and drives the downstream entropy/quantisation stage one element per beat. It is the reading end of the flat-tensor interface that the conv/resblock stages write. Element coordinates and a last-of-tensor marker travel with each element.

---
 rtl/tensor_serializer.sv | 162 ++++++++++++++++
 tb/tb_tensor_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_serializer.sv
// Streams a packed tensor one element per valid/ready beat, tagging each with b/c/h/w coordinates and a last flag.
// Optional macro TENSOR_SERIALIZER_PINGPONG_EN adds a pending buffer so consecutive tensors stream with no bubble.
module tensor_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS   = 1,
  parameter int HEIGHT     = 2,
  parameter int WIDTH      = 2,
  localparam int TOTAL = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH,
  localparam int BW    = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int HW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int WW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [TOTAL*DATA_WIDTH-1:0] tensor_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [BW-1:0]               m_b,
  output logic [CW-1:0]               m_c,
  output logic [HW-1:0]               m_h,
  output logic [WW-1:0]               m_w,
  output logic                        m_last
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [BW-1:0] B_MAX = BW'(BATCH_SIZE - 1);
  localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HEIGHT - 1);
  localparam logic [WW-1:0] W_MAX = WW'(WIDTH - 1);

  state_t                      state;
  logic [TOTAL*DATA_WIDTH-1:0] act_buf;
  logic                        valid_q;
  logic                        ready_q;
  logic                        ready_nxt;
  logic                        restart;
  logic                        load_fire;
  logic                        beat;
  logic                        at_last;
  logic                        last_beat;

  assign load_fire  = load_valid && ready_q;
  assign beat       = valid_q && m_ready;
  assign at_last    = (m_b == B_MAX) && (m_c == C_MAX) && (m_h == H_MAX) && (m_w == W_MAX);
  assign last_beat  = beat && at_last;
  assign m_valid    = valid_q;
  assign load_ready = ready_q;
  assign m_last     = valid_q && at_last;
  // The active buffer shifts left on every beat, so the current element is always the MSB slice.
  assign m_data     = act_buf[TOTAL*DATA_WIDTH-1 -: DATA_WIDTH];

`ifdef TENSOR_SERIALIZER_PINGPONG_EN
  logic [TOTAL*DATA_WIDTH-1:0] pend_buf;
  logic                        pend_full;
  logic                        pend_full_nxt;

  always_comb begin
    pend_full_nxt = pend_full;
    if (last_beat && pend_full) begin
      pend_full_nxt = 1'b0;
    end else if (load_fire && (state == STREAM) && !last_beat) begin
      pend_full_nxt = 1'b1;
    end
  end

  assign ready_nxt = !pend_full_nxt;
  assign restart   = pend_full || load_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full <= 1'b0;
    end else begin
      pend_full <= pend_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire && (state == STREAM) && !last_beat) begin
      pend_buf <= tensor_in;
    end
  end
`else
  assign ready_nxt = ((state == IDLE) && !load_fire) || last_beat;
  assign restart   = 1'b0;
`endif

  always_ff @(posedge clk) begin
`ifdef TENSOR_SERIALIZER_PINGPONG_EN
    if (last_beat && pend_full) begin
      act_buf <= pend_buf;
    end else
`endif
    if (load_fire && ((state == IDLE) || last_beat)) begin
      act_buf <= tensor_in;
    end else if (beat) begin
      act_buf <= act_buf << DATA_WIDTH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      m_b     <= '0;
      m_c     <= '0;
      m_h     <= '0;
      m_w     <= '0;
    end else begin
      ready_q <= ready_nxt;
      case (state)
        IDLE: begin
          if (load_fire) begin
            state   <= STREAM;
            valid_q <= 1'b1;
            m_b     <= '0;
            m_c     <= '0;
            m_h     <= '0;
            m_w     <= '0;
          end
        end
        STREAM: begin
          if (beat) begin
            if (at_last) begin
              m_b <= '0;
              m_c <= '0;
              m_h <= '0;
              m_w <= '0;
              if (!restart) begin
                state   <= IDLE;
                valid_q <= 1'b0;
              end
            end else if (m_w != W_MAX) begin
              m_w <= m_w + WW'(1);
            end else begin
              m_w <= '0;
              if (m_h != H_MAX) begin
                m_h <= m_h + HW'(1);
              end else begin
                m_h <= '0;
                if (m_c != C_MAX) begin
                  m_c <= m_c + CW'(1);
                end else begin
                  m_c <= '0;
                  m_b <= m_b + BW'(1);
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_serializer.sv
// Self-checking bench for tensor_serializer: table-driven sequences, hand-written corner cases and a randomized model check.
module tb_tensor_serializer;

`ifdef TENSOR_SERIALIZER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif
  localparam int NB = 1, NC = 1, NH = 2, NW = 2, TOT = NB * NC * NH * NW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_a = 1'b0, lr_a, v_a, rdy_a = 1'b0, last_a;
  logic [31:0] tin_a = '0;
  logic [7:0]  d_a;
  logic        b_a, c_a, h_a, w_a;
  logic        ld_b = 1'b0, lr_b, v_b, rdy_b = 1'b0, last_b;
  logic [31:0] tin_b = '0;
  logic [7:0]  d_b;
  logic        b_b, c_b, h_b, w_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tensor_serializer dut_a (
    .clk(clk), .rst(rst), .load_valid(ld_a), .load_ready(lr_a), .tensor_in(tin_a),
    .m_valid(v_a), .m_ready(rdy_a), .m_data(d_a), .m_b(b_a), .m_c(c_a), .m_h(h_a),
    .m_w(w_a), .m_last(last_a)
  );

  tensor_serializer #(.CHANNELS(2), .HEIGHT(1), .WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .load_valid(ld_b), .load_ready(lr_b), .tensor_in(tin_b),
    .m_valid(v_b), .m_ready(rdy_b), .m_data(d_b), .m_b(b_b), .m_c(c_b), .m_h(h_b),
    .m_w(w_b), .m_last(last_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       ld;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       eh;
    logic       ew;
    logic       el;
    logic       elr;
  } row_t;

  typedef struct {
    logic [7:0] data;
    int         b, c, h, w;
    logic       last;
  } elem_t;

  function automatic row_t mk(logic ld, logic rdy, logic ev, logic [7:0] ed,
                              logic eh, logic ew, logic el, logic elr);
    row_t r;
    r.ld = ld; r.rdy = rdy; r.ev = ev; r.ed = ed;
    r.eh = eh; r.ew = ew; r.el = el; r.elr = elr;
    return r;
  endfunction

  row_t        tbl[15];
  logic [8:0]  bb_exp[10];
  elem_t       q[$];
  elem_t       e;
  int          beats;
  int          fires;
  int          loads_left;
  int          cyc;
  logic [7:0]  seq_data;

  initial begin
    // Basic stream, bubble, then the 0,0,1,0,1,1,0,1 backpressure pattern.
    tbl[0]  = mk(1, 1, 0, 8'd0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 1, 8'd1, 0, 0, 0, PP);
    tbl[2]  = mk(0, 1, 1, 8'd2, 0, 1, 0, PP);
    tbl[3]  = mk(0, 1, 1, 8'd3, 1, 0, 0, PP);
    tbl[4]  = mk(0, 1, 1, 8'd4, 1, 1, 1, PP);
    tbl[5]  = mk(1, 0, 0, 8'd0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 1, 8'd1, 0, 0, 0, PP);
    tbl[7]  = mk(0, 0, 1, 8'd1, 0, 0, 0, PP);
    tbl[8]  = mk(0, 1, 1, 8'd1, 0, 0, 0, PP);
    tbl[9]  = mk(0, 0, 1, 8'd2, 0, 1, 0, PP);
    tbl[10] = mk(0, 1, 1, 8'd2, 0, 1, 0, PP);
    tbl[11] = mk(0, 1, 1, 8'd3, 1, 0, 0, PP);
    tbl[12] = mk(0, 0, 1, 8'd4, 1, 1, 1, PP);
    tbl[13] = mk(0, 1, 1, 8'd4, 1, 1, 1, PP);
    tbl[14] = mk(0, 0, 0, 8'd0, 0, 0, 0, 1);

    if (PP) begin
      bb_exp = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h109, 9'h109, 9'h109, 9'h109, 9'h000, 9'h000};
    end else begin
      bb_exp = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h000, 9'h109, 9'h109, 9'h109, 9'h109, 9'h000};
    end

    // Reset state held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", v_a, 0);
      chk("rst_last", last_a, 0);
      chk("rst_load_ready", lr_a, 0);
      chk("rst_coords", {b_a, c_a, h_a, w_a}, 0);
      chk("rst_b_valid", v_b, 0);
    end
    rst = 1'b1;

    tin_a = 32'h01020304;
    beats = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), v_a, tbl[i].ev);
      chk($sformatf("tbl%0d_last", i), last_a, tbl[i].el);
      chk($sformatf("tbl%0d_load_ready", i), lr_a, tbl[i].elr);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), d_a, tbl[i].ed);
        chk($sformatf("tbl%0d_hw", i), {h_a, w_a}, {tbl[i].eh, tbl[i].ew});
        if (tbl[i].rdy) beats++;
      end
      ld_a  = tbl[i].ld;
      rdy_a = tbl[i].rdy;
    end
    chk("tbl_beat_count", beats, 8);

    // Reset mid-stream after the second beat.
    @(negedge clk);
    ld_a = 1'b1; tin_a = 32'h01020304; rdy_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    chk("mid_first", d_a, 8'd1);
    @(negedge clk);
    chk("mid_second", d_a, 8'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", v_a, 0);
    chk("mid_rst_last", last_a, 0);
    chk("mid_rst_coords", {h_a, w_a}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_load_ready", lr_a, 1);
    chk("mid_rel_valid", v_a, 0);
    ld_a = 1'b1; tin_a = 32'h05060708;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ld_a = 1'b0;
      seq_data = 8'(5 + k);
      chk("mid_reload_valid", v_a, 1);
      chk("mid_reload_data", d_a, seq_data);
      chk("mid_reload_last", last_a, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("mid_reload_done", v_a, 0);

    // Back-to-back tensors with load_valid held high.
    fires = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i), v_a, bb_exp[i-1][8]);
        if (bb_exp[i-1][8]) chk($sformatf("b2b%0d_data", i), d_a, bb_exp[i-1][7:0]);
      end
      tin_a = (fires == 0) ? 32'h01020304 : 32'h09090909;
      ld_a  = (fires < 2);
      if (ld_a && lr_a) fires++;
    end
    ld_a = 1'b0;
    chk("b2b_loads", fires, 2);

    // Multi-channel order on the second instance.
    @(negedge clk);
    chk("mc_load_ready", lr_b, 1);
    ld_b = 1'b1; tin_b = 32'h0A0B1415; rdy_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ld_b = 1'b0;
      chk("mc_valid", v_b, 1);
      chk("mc_data", d_b, (k == 0) ? 8'd10 : (k == 1) ? 8'd11 : (k == 2) ? 8'd20 : 8'd21);
      chk("mc_cw", {c_b, h_b, w_b}, {1'(k / 2), 1'b0, 1'(k % 2)});
      chk("mc_last", last_b, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("mc_done", v_b, 0);

    // Randomized loads and backpressure against the element-queue model.
    loads_left = 40;
    cyc = 0;
    while ((loads_left > 0 || q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!v_a) chk("rnd_idle_last", last_a, 0);
      rdy_a = ($urandom_range(0, 3) != 0);
      if (v_a && rdy_a) begin
        chk("rnd_expected_beat", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rnd_data", d_a, e.data);
          chk("rnd_b", b_a, e.b);
          chk("rnd_c", c_a, e.c);
          chk("rnd_h", h_a, e.h);
          chk("rnd_w", w_a, e.w);
          chk("rnd_last", last_a, e.last);
        end
      end
      ld_a = 1'b0;
      if (loads_left > 0 && $urandom_range(0, 1) == 1) begin
        ld_a  = 1'b1;
        tin_a = $urandom();
        if (lr_a) begin
          loads_left--;
          for (int k = 0; k < TOT; k++) begin
            e.data = tin_a[(TOT-k)*8-1 -: 8];
            e.w    = k % NW;
            e.h    = (k / NW) % NH;
            e.c    = (k / (NW * NH)) % NC;
            e.b    = k / (NW * NH * NC);
            e.last = (k == TOT - 1);
            q.push_back(e);
          end
        end
      end
    end
    ld_a = 1'b0;
    chk("rnd_all_loaded", loads_left, 0);
    chk("rnd_drained", q.size(), 0);
    @(negedge clk);
    chk("rnd_final_idle", v_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
